// File: rtl/uart_rx_frame_check.sv
// UART frame tail checker: samples parity/stop bits by 3-point majority after check_start; done
// pulses (2+par_en+stop_bits)*prescale+1 cycles later; check_start is ignored while busy. Break detect under UART_RX_BREAK_DETECT_EN.
module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  check_start,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_en,
    input  logic                  par_type,
    input  logic                  stop_bits,
    output logic                  busy,
    output logic                  done,
    output logic                  par_error,
    output logic                  stop_error,
    output logic                  break_det
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_done;
    logic [PRESCALE_W-1:0] r_cnt;
    logic                  r_lead;
    logic [2:0]            r_smp;
    logic                  r_par_en;
    logic                  r_par_type;
    logic                  r_stop_bits;
    logic                  r_par_bit;
    logic                  r_stop_err;
    logic                  r_par_error;
    logic                  r_stop_error;

    logic [PRESCALE_W-1:0] w_half;
    logic                  w_start;
    logic                  w_in_bit;
    logic                  w_wrap;
    logic                  w_bit_end;
    logic                  w_maj;
    logic                  w_par_err_now;

    assign w_half    = prescale >> 1;
    assign w_start   = check_start && (r_state == S_IDLE);
    assign w_in_bit  = (r_state == S_PARITY) || (r_state == S_STOP1) || (r_state == S_STOP2);
    assign w_wrap    = (r_cnt == prescale - PRESCALE_W'(1));
    // The first bit period after check_start is a guard period: counted, never sampled.
    assign w_bit_end = w_in_bit && w_wrap && !r_lead;
    assign w_maj     = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (check_start) begin
                    w_next = par_en ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_next = S_STOP1;
                end
            end
            S_STOP1: begin
                if (w_bit_end) begin
                    w_next = r_stop_bits ? S_STOP2 : S_DONE;
                end
            end
            S_STOP2: begin
                if (w_bit_end) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_lead <= 1'b0;
        end else if (w_start) begin
            r_cnt  <= '0;
            r_lead <= 1'b1;
        end else if (w_in_bit) begin
            r_cnt <= w_wrap ? '0 : r_cnt + PRESCALE_W'(1);
            if (w_wrap) begin
                r_lead <= 1'b0;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_smp <= '0;
        end else if (w_in_bit) begin
            if (r_cnt == w_half - PRESCALE_W'(1)) r_smp[0] <= rx_in;
            if (r_cnt == w_half)                  r_smp[1] <= rx_in;
            if (r_cnt == w_half + PRESCALE_W'(1)) r_smp[2] <= rx_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_par_en    <= 1'b0;
            r_par_type  <= 1'b0;
            r_stop_bits <= 1'b0;
            r_par_bit   <= 1'b0;
            r_stop_err  <= 1'b0;
        end else if (w_start) begin
            r_par_en    <= par_en;
            r_par_type  <= par_type;
            r_stop_bits <= stop_bits;
            r_par_bit   <= 1'b0;
            r_stop_err  <= 1'b0;
        end else if (w_bit_end) begin
            if (r_state == S_PARITY) begin
                r_par_bit <= w_maj;
            end else if (!w_maj) begin
                r_stop_err <= 1'b1;
            end
        end
    end

    assign w_par_err_now = r_par_en && (r_par_bit != ((^data) ^ r_par_type));

    // Flags are live in the done cycle and held in registers until the next done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_par_error  <= 1'b0;
            r_stop_error <= 1'b0;
        end else if (w_done) begin
            r_par_error  <= w_par_err_now;
            r_stop_error <= r_stop_err;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = w_done;
    assign par_error  = w_done ? w_par_err_now : r_par_error;
    assign stop_error = w_done ? r_stop_err : r_stop_error;

`ifdef UART_RX_BREAK_DETECT_EN
    logic r_line_low;
    logic r_break_det;
    logic w_break_now;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_line_low <= 1'b0;
        end else if (w_start) begin
            r_line_low <= 1'b1;
        end else if (w_bit_end && w_maj) begin
            r_line_low <= 1'b0;
        end
    end

    assign w_break_now = (data == '0) && r_line_low;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_break_det <= 1'b0;
        end else if (w_done) begin
            r_break_det <= w_break_now;
        end
    end

    assign break_det = w_done ? w_break_now : r_break_det;
`else
    assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed and randomized frames checked against a per-cycle line model of the frame tail.
module tb_uart_rx_frame_check;
    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_in = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          check_start = 1'b0;
    logic [DW-1:0] data = '0;
    logic          par_en = 1'b0;
    logic          par_type = 1'b0;
    logic          stop_bits = 1'b0;
    logic          busy, done, par_error, stop_error, break_det;

    int checks = 0;
    int failures = 0;

    // Line model: slot 0 is the guard period after check_start, then parity/stop bits.
    int   m_p;
    int   m_nslots;
    int   m_glitch;
    logic m_slot [0:3];

    always #5 clk = ~clk;

    uart_rx_frame_check #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
        .check_start(check_start), .data(data), .par_en(par_en),
        .par_type(par_type), .stop_bits(stop_bits), .busy(busy), .done(done),
        .par_error(par_error), .stop_error(stop_error), .break_det(break_det)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle c counts clock periods after the check_start cycle (c=0).
    function automatic logic line_at(input int c);
        int   s;
        logic v;
        s = (c < 1) ? 0 : (c - 1) / m_p;
        v = 1'b1;
        if (s < m_nslots) v = m_slot[s];
        if (c == m_glitch) v = ~v;
        return v;
    endfunction

    function automatic logic maj_of(input int slot);
        int base;
        int sum;
        base = slot * m_p + 1;
        sum = int'(line_at(base + m_p/2 - 1)) + int'(line_at(base + m_p/2)) + int'(line_at(base + m_p/2 + 1));
        return (sum >= 2);
    endfunction

    task automatic run_frame(input string name, input int p, input logic pe, input logic pt,
                             input logic sb, input logic [DW-1:0] dat, input logic pbit,
                             input logic s1, input logic s2, input int glitch, input bit poke);
        int   idx, n, lat;
        logic mp, ms1, ms2, exp_pe, exp_se, exp_bd;
        bit   seen;
        m_p = p;
        m_glitch = glitch;
        m_slot[0] = pe ? pbit : s1;
        idx = 1;
        if (pe) begin m_slot[idx] = pbit; idx++; end
        m_slot[idx] = s1; idx++;
        if (sb) begin m_slot[idx] = s2; idx++; end
        m_nslots = idx;

        mp = 1'b1;
        idx = 1;
        if (pe) begin mp = maj_of(1); idx = 2; end
        ms1 = maj_of(idx);
        ms2 = sb ? maj_of(idx + 1) : 1'b1;
        exp_pe = pe && (mp != ((^dat) ^ pt));
        exp_se = !ms1 || !ms2;
`ifdef UART_RX_BREAK_DETECT_EN
        exp_bd = (dat == '0) && (!pe || !mp) && !ms1 && !ms2;
`else
        exp_bd = 1'b0;
`endif
        lat = (2 + int'(pe) + int'(sb)) * p + 1;

        @(posedge clk); #1;
        prescale = PW'(p); data = dat; par_en = pe; par_type = pt; stop_bits = sb;
        check_start = 1'b1;
        rx_in = line_at(0);
        n = 0;
        seen = 0;
        while (!seen && n < 300) begin
            @(posedge clk); #1;
            n++;
            check_start = poke && (n == 5);
            if (poke) begin
                par_en = 1'($urandom); par_type = 1'($urandom); stop_bits = 1'($urandom);
            end
            rx_in = line_at(n);
            if (n == 1) chk({name, " busy"}, 32'(busy), 32'd1);
            if (done) seen = 1;
        end
        chk({name, " latency"}, seen ? n : -1, lat);
        chk({name, " par_error"}, 32'(par_error), 32'(exp_pe));
        chk({name, " stop_error"}, 32'(stop_error), 32'(exp_se));
        chk({name, " break_det"}, 32'(break_det), 32'(exp_bd));
        @(posedge clk); #1;
        check_start = 1'b0;
        rx_in = 1'b1;
        chk({name, " done_one_cycle"}, 32'(done), 32'd0);
        chk({name, " idle_after"}, 32'(busy), 32'd0);
        chk({name, " par_hold"}, 32'(par_error), 32'(exp_pe));
        chk({name, " stop_hold"}, 32'(stop_error), 32'(exp_se));
    endtask

    initial begin
        int   n, pulses, p, g, lat;
        logic pe, sb;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset flags", {29'd0, par_error, stop_error, break_det}, 32'd0);
        rst = 1'b1;

        run_frame("min_frame", 8, 0, 0, 0, 8'h3C, 1, 1, 1, 0, 0);
        run_frame("parity_bad", 16, 1, 0, 0, 8'hA5, 1, 1, 1, 0, 0);
        run_frame("parity_ok", 16, 1, 0, 0, 8'hA5, 0, 1, 1, 0, 0);
        run_frame("odd_parity", 8, 1, 1, 1, 8'h07, 1, 1, 1, 0, 0);
        run_frame("glitch_stop", 8, 0, 0, 0, 8'h55, 1, 1, 1, 13, 0);
        run_frame("break_line", 8, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        run_frame("stop2_low", 16, 0, 0, 1, 8'hFF, 1, 1, 0, 0, 0);

        // Abort a frame while in its first stop bit; the previous stop_error must clear.
        @(posedge clk); #1;
        prescale = PW'(8); par_en = 1'b0; stop_bits = 1'b1; data = 8'h81;
        check_start = 1'b1;
        rx_in = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            check_start = 1'b0;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort flags", {29'd0, par_error, stop_error, break_det}, 32'd0);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort no_done", pulses, 0);
        run_frame("after_abort", 8, 0, 0, 1, 8'h42, 1, 1, 1, 0, 0);

        for (int t = 0; t < 12; t++) begin
            p  = 8 << $urandom_range(0, 2);
            pe = 1'($urandom);
            sb = 1'($urandom);
            lat = (2 + int'(pe) + int'(sb)) * p + 1;
            g  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, lat - 1)) : 0;
            run_frame($sformatf("rand%0d", t), p, pe, 1'($urandom), sb, 8'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), g, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_check.md
UART_RX_FRAME_CHECK -- requirements
Module: uart_rx_frame_check

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, number of data bits per frame (5..9).
REQ-002 SHALL provide parameter PRESCALE_W, default 6, width of the prescale and edge-counter fields.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 rx_in  input  1  serial line, already synchronised to clk.
REQ-006 prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32; held stable while busy.
REQ-007 check_start  input  1  one-cycle pulse from RX FSM on the first clk of the bit after the last data bit.
REQ-008 data  input  DATA_WIDTH  received data word; stable from check_start until done.
REQ-009 par_en  input  1  1 = parity bit present.
REQ-010 par_type  input  1  0 = even, 1 = odd.
REQ-011 stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-012 busy  output  1  high from the cycle after check_start until done.
REQ-013 done  output  1  one-cycle pulse; error flags are valid in this cycle.
REQ-014 par_error  output  1  parity mismatch on the last frame; held until next done.
REQ-015 stop_error  output  1  any stop bit sampled 0 on the last frame; held until next done.
REQ-016 break_det  output  1  break condition on the last frame; held until next done.

Function
REQ-017 SHALL implement FSM states IDLE, PARITY, STOP1, STOP2, DONE.
REQ-018 IDLE -> PARITY on check_start when par_en=1; IDLE -> STOP1 on check_start when par_en=0.
REQ-019 PARITY -> STOP1, STOP1 -> STOP2 (stop_bits=1) or DONE (stop_bits=0), STOP2 -> DONE, each at end of bit.
REQ-020 DONE asserts done for exactly one cycle, updates par_error/stop_error/break_det in the same cycle, then returns to IDLE.
REQ-021 Internal edge counter SHALL reset to 0 on check_start, increment each clk, and wrap to 0 at prescale-1; wrap marks end of bit.
REQ-022 Each bit SHALL be sampled at edge counts prescale/2-1, prescale/2, prescale/2+1; bit value = 2-of-3 majority.
REQ-023 Expected parity = XOR of data (even) or its inverse (odd); par_error = sampled parity != expected; par_error = 0 when par_en=0.
REQ-024 stop_error = 1 if any checked stop bit majority value is 0.
REQ-025 check_start while busy SHALL be ignored.
REQ-026 Frame latency: done asserted on the cycle after the final bit's edge counter wrap, i.e. (1+par_en+1+stop_bits)*prescale+1 cycles after check_start.
REQ-027 Inputs par_en, par_type, stop_bits SHALL be captured on check_start; later changes do not affect the frame in progress.

Reset
REQ-028 With rst=0 at a clock edge: FSM to IDLE, edge counter 0, busy=0, done=0, par_error=0, stop_error=0, break_det=0.
REQ-029 Reset mid-frame SHALL abort the frame with no done pulse; next check_start starts a fresh frame.

Configuration
REQ-030 Macro UART_RX_BREAK_DETECT_EN defined: break_det=1 at done when data is all zero, sampled parity (if par_en) is 0, and all stop bits sampled 0.
REQ-031 Macro UART_RX_BREAK_DETECT_EN undefined: break_det tied to 0, no break logic synthesised; all other behaviour identical.

Verification
REQ-032 prescale=8, par_en=0, stop_bits=0, rx_in=1 -> done at cycle 17 after check_start, stop_error=0, par_error=0.
REQ-033 prescale=16, par_en=1, par_type=0, data=8'hA5, parity bit 1 -> par_error=1; parity bit 0 -> par_error=0.
REQ-034 prescale=16, stop_bits=1, second stop bit held 0 -> stop_error=1, done at cycle 49 (par_en=0).
REQ-035 prescale=8, single-cycle 0 glitch at edge count 4 of stop bit -> majority 1, stop_error=0.
REQ-036 UART_RX_BREAK_DETECT_EN defined, data=8'h00, par_en=1, rx_in=0 throughout -> break_det=1, stop_error=1; macro undefined -> break_det=0.
REQ-037 rst=0 asserted in STOP1 -> no done pulse, all outputs 0 next cycle; following check_start completes normally.
